// File: rtl/rs232_tx_queue.sv
// ---------------------------------------------------------------------------
// rs232_tx_queue
//
// Byte-wide transmit queue and start sequencer sitting in front of the RS232
// transmitter. The solver core pushes bytes in bursts (one per cycle). The
// bytes are held in a circular FIFO. They are then handed to the serial
// transmitter one at a time. Each hand-off uses a single-cycle start pulse
// and honours the transmitter's busy flag, so the core never waits on
// serial timing.
//
// Ports
//   iCLK        system clock
//   RST_n       asynchronous active-low reset
//   iWR_DATA    byte to enqueue
//   iWR_EN      enqueue strobe, one byte per cycle
//   oFULL       FIFO holds 2**DEPTH_LOG2 bytes
//   oEMPTY      FIFO holds no bytes
//   oCOUNT      current occupancy (DEPTH_LOG2+1 bits)
//   oOVERFLOW   sticky: a write was dropped because the FIFO was full
//   oTxD_DATA   byte presented to the transmitter
//   oTxD_Start  one-cycle start pulse to the transmitter
//   iTxD_Busy   transmitter busy flag
//
// Parameters
//   DEPTH_LOG2  log2 of the FIFO depth
//   BUSY_WAIT   cycles to wait after a start pulse for busy to rise before
//               the byte is taken as accepted (guards against a transmitter
//               that never raises busy)
// ---------------------------------------------------------------------------
module rs232_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                iCLK,
    input  logic                RST_n,
    input  logic [7:0]          iWR_DATA,
    input  logic                iWR_EN,
    output logic                oFULL,
    output logic                oEMPTY,
    output logic [DEPTH_LOG2:0] oCOUNT,
    output logic                oOVERFLOW,
    output logic [7:0]          oTxD_DATA,
    output logic                oTxD_Start,
    input  logic                iTxD_Busy
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TIMER_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } txState_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]            fifoMem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [7:0]            txData;
    logic                  txStart;
    logic [TIMER_W-1:0]    timer;
    txState_t              state;
    txState_t              stateNext;

    // Sequencer decisions for the current cycle
    logic loadNow;
    logic popNow;
    logic timerClear;
    logic timerInc;
    logic wrAccept;

    // Full is judged on the registered occupancy. A pop in the same cycle
    // does not make room for a write arriving while full.
    assign wrAccept = iWR_EN && !oFULL;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        stateNext  = state;
        loadNow    = 1'b0;
        popNow     = 1'b0;
        timerClear = 1'b0;
        timerInc   = 1'b0;

        case (state)
            IDLE: begin
                if ((count != '0) && !iTxD_Busy) begin
                    loadNow   = 1'b1;
                    stateNext = START;
                end
            end

            START: begin
                // The pulse cycle is also the cycle the byte leaves the FIFO.
                popNow     = 1'b1;
                timerClear = 1'b1;
                stateNext  = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (iTxD_Busy) begin
                    stateNext = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    // Busy never showed up; treat the byte as taken.
                    stateNext = WAIT_DONE;
                end else begin
                    timerInc = 1'b1;
                end
            end

            WAIT_DONE: begin
                if (!iTxD_Busy) begin
                    stateNext = IDLE;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer registers
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge RST_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values regardless of statement order.
        if (!RST_n) begin
            state   <= IDLE;
            timer   <= '0;
            txStart <= 1'b0;
            txData  <= 8'h00;
        end else begin
            state <= stateNext;

            // START lasts exactly one cycle, so the registered pulse is high
            // for exactly that cycle.
            txStart <= (stateNext == START);

            if (timerClear) begin
                timer <= '0;
            end else if (timerInc) begin
                timer <= timer + 1'b1;
            end

            // Load only happens in IDLE with the transmitter idle. The byte
            // therefore stays stable through the pulse and the busy period.
            if (loadNow) begin
                txData <= fifoMem[rdPtr];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // -----------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end

            // A pop is only issued with count >= 1. The read slot can
            // therefore never be the slot being written this cycle.
            if (popNow) begin
                rdPtr <= rdPtr + 1'b1;
            end

            case ({wrAccept, popNow})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (iWR_EN && oFULL) begin
                overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // NOTE: the data array has no reset. Occupancy and pointers define which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge iCLK) begin
        if (wrAccept) begin
            fifoMem[wrPtr] <= iWR_DATA;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign oCOUNT     = count;
    assign oFULL      = (count == COUNT_FULL);
    assign oEMPTY     = (count == '0);
    assign oOVERFLOW  = overflow;
    assign oTxD_DATA  = txData;
    assign oTxD_Start = txStart;

endmodule

// File: tb/tb_rs232_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_rs232_tx_queue
//
// Self-checking bench for rs232_tx_queue.
//
// The bench pushes every byte it expects to see transmitted onto a
// scoreboard queue when it drives the write. A transmitter model pops that
// queue on each start pulse, compares the presented byte, and then raises
// busy for a programmable number of cycles. The burst/overflow phase is
// table driven. Latency, simultaneous write+pop, busy timeout and
// mid-operation reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_rs232_tx_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int BUSY_WAIT  = 4;

    logic                iCLK = 1'b0;
    logic                RST_n = 1'b0;
    logic [7:0]          iWR_DATA = 8'h00;
    logic                iWR_EN = 1'b0;
    logic                oFULL;
    logic                oEMPTY;
    logic [DEPTH_LOG2:0] oCOUNT;
    logic                oOVERFLOW;
    logic [7:0]          oTxD_DATA;
    logic                oTxD_Start;
    logic                iTxD_Busy = 1'b0;

    rs232_tx_queue #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BUSY_WAIT  (BUSY_WAIT)
    ) dut (
        .iCLK       (iCLK),
        .RST_n      (RST_n),
        .iWR_DATA   (iWR_DATA),
        .iWR_EN     (iWR_EN),
        .oFULL      (oFULL),
        .oEMPTY     (oEMPTY),
        .oCOUNT     (oCOUNT),
        .oOVERFLOW  (oOVERFLOW),
        .oTxD_DATA  (oTxD_DATA),
        .oTxD_Start (oTxD_Start),
        .iTxD_Busy  (iTxD_Busy)
    );

    initial forever #5 iCLK = ~iCLK;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  sbQ[$];
    int          startCount = 0;
    int          startCycles[$];
    logic        holdBusy = 1'b0;
    int          busyLen  = 0;
    int          busyCnt  = 0;
    logic [7:0]  expData  = 8'h00;

    initial forever begin
        @(posedge iCLK);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Move to the middle of the next clock low phase, away from the edges.
    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Transmitter model + scoreboard consumer (acts on the falling edge)
    // -----------------------------------------------------------------------
    initial forever begin
        @(negedge iCLK);
        if (!RST_n) begin
            busyCnt = 0;
            expData = 8'h00;
        end else begin
            // While the transmitter is busy the presented byte must not move.
            if (iTxD_Busy) begin
                check("data_stable_while_busy", oTxD_DATA, expData);
            end
            if (oTxD_Start) begin
                check("start_while_busy", iTxD_Busy, 1'b0);
                startCount++;
                startCycles.push_back(cyc);
                checks++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected: got byte %02h, expected no byte pending (cycle %0d)",
                             oTxD_DATA, cyc);
                end else begin
                    expData = sbQ.pop_front();
                    if (oTxD_DATA !== expData) begin
                        failures++;
                        $display("FAIL tx_data: got %02h, expected %02h (cycle %0d)",
                                 oTxD_DATA, expData, cyc);
                    end
                end
                busyCnt = busyLen;
            end else if (busyCnt > 0) begin
                busyCnt--;
            end
        end
        iTxD_Busy = holdBusy || (busyCnt > 0);
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic applyReset(input logic hold);
        RST_n    = 1'b0;
        iWR_EN   = 1'b0;
        holdBusy = hold;
        sbQ.delete();
        tick();
        tick();
        RST_n = 1'b1;
        tick();
    endtask

    task automatic writeByte(input logic [7:0] d, input bit expectAccept);
        iWR_EN   = 1'b1;
        iWR_DATA = d;
        if (expectAccept) sbQ.push_back(d);
        tick();
        iWR_EN = 1'b0;
    endtask

    task automatic waitStarts(input int target, input int budget);
        int n = 0;
        while (startCount < target && n < budget) begin
            tick();
            n++;
        end
        check("start_count", startCount, target);
    endtask

    task automatic waitStartPulse(input int budget);
        int n = 0;
        while (!oTxD_Start && n < budget) begin
            tick();
            n++;
        end
        check("start_seen", oTxD_Start, 1'b1);
    endtask

    // -----------------------------------------------------------------------
    // Burst / overflow vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic                wrEn;
        logic [7:0]          data;
        bit                  accept;
        logic [DEPTH_LOG2:0] expCount;
        logic                expFull;
        logic                expEmpty;
        logic                expOvf;
    } vec_t;

    vec_t vecs [18];

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int wrCyc;
        int base;
        int guard;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i + 1), 1'b1, 5'(i + 1), (i == 15), 1'b0, 1'b0};
        end
        vecs[16] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};

        // ---- reset values ------------------------------------------------
        applyReset(1'b0);
        check("rst_start", oTxD_Start, 1'b0);
        check("rst_data", oTxD_DATA, 8'h00);
        check("rst_count", oCOUNT, 0);
        check("rst_empty", oEMPTY, 1'b1);
        check("rst_full", oFULL, 1'b0);
        check("rst_ovf", oOVERFLOW, 1'b0);

        // ---- single byte latency -----------------------------------------
        busyLen = 3;
        repeat (3) tick();
        base  = startCount;
        wrCyc = cyc;
        writeByte(8'hA5, 1'b1);
        check("lat_count_n1", oCOUNT, 1);
        check("lat_nostart_n1", oTxD_Start, 1'b0);
        tick();
        check("lat_start_n2", oTxD_Start, 1'b1);
        check("lat_data_n2", oTxD_DATA, 8'hA5);
        check("lat_start_cycle", startCycles[startCycles.size() - 1], wrCyc + 2);
        repeat (8) tick();
        check("single_empty", oEMPTY, 1'b1);
        check("single_one_pulse", startCount - base, 1);
        // FSM must be back in IDLE: a new byte starts with the same latency.
        wrCyc = cyc;
        writeByte(8'h3C, 1'b1);
        tick();
        check("idle_again_start", oTxD_Start, 1'b1);
        check("idle_again_cycle", startCycles[startCycles.size() - 1], wrCyc + 2);
        repeat (8) tick();

        // ---- burst fill + overflow (table) -------------------------------
        busyLen = 100;
        applyReset(1'b1);
        tick();
        base = startCount;
        foreach (vecs[i]) begin
            iWR_EN   = vecs[i].wrEn;
            iWR_DATA = vecs[i].data;
            if (vecs[i].accept) sbQ.push_back(vecs[i].data);
            tick();
            check($sformatf("vec%0d_count", i), oCOUNT, vecs[i].expCount);
            check($sformatf("vec%0d_full", i), oFULL, vecs[i].expFull);
            check($sformatf("vec%0d_empty", i), oEMPTY, vecs[i].expEmpty);
            check($sformatf("vec%0d_ovf", i), oOVERFLOW, vecs[i].expOvf);
        end
        iWR_EN   = 1'b0;
        holdBusy = 1'b0;
        waitStarts(base + 16, 3000);
        repeat (110) tick();
        check("burst_drained_empty", oEMPTY, 1'b1);
        check("burst_drained_count", oCOUNT, 0);
        check("burst_ovf_sticky", oOVERFLOW, 1'b1);
        check("burst_sb_left", sbQ.size(), 0);

        // ---- simultaneous write + pop, pointer wrap over 40 bytes -------
        busyLen = 2;
        applyReset(1'b1);
        tick();
        base = startCount;
        for (int i = 0; i < 5; i++) writeByte(8'h40 + 8'(i), 1'b1);
        check("pre_pop_count", oCOUNT, 5);
        holdBusy = 1'b0;
        waitStartPulse(10);
        check("start_cycle_count", oCOUNT, 5);
        writeByte(8'h45, 1'b1);
        check("wr_pop_same_cycle_count", oCOUNT, 5);
        for (int i = 0; i < 34; i++) begin
            guard = 0;
            while (sbQ.size() >= 14 && guard < 200) begin
                tick();
                guard++;
            end
            writeByte(8'h46 + 8'(i), 1'b1);
        end
        waitStarts(base + 40, 2000);
        repeat (10) tick();
        check("wrap_empty", oEMPTY, 1'b1);
        check("wrap_ovf_clear", oOVERFLOW, 1'b0);
        check("wrap_sb_left", sbQ.size(), 0);

        // ---- busy timeout ------------------------------------------------
        busyLen = 0;
        applyReset(1'b1);
        tick();
        base = startCycles.size();
        writeByte(8'h71, 1'b1);
        writeByte(8'h72, 1'b1);
        writeByte(8'h73, 1'b1);
        holdBusy = 1'b0;
        waitStarts(startCount + 3, 100);
        repeat (10) tick();
        if (startCycles.size() >= base + 3) begin
            check("timeout_gap1", startCycles[base + 1] - startCycles[base], 7);
            check("timeout_gap2", startCycles[base + 2] - startCycles[base + 1], 7);
        end
        check("timeout_empty", oEMPTY, 1'b1);

        // ---- reset mid-operation ----------------------------------------
        busyLen = 50;
        applyReset(1'b1);
        tick();
        for (int i = 0; i < 7; i++) writeByte(8'h81 + 8'(i), 1'b1);
        holdBusy = 1'b0;
        waitStartPulse(10);
        repeat (5) tick();
        check("pre_reset_count", oCOUNT, 6);
        RST_n = 1'b0;
        #1;
        check("async_rst_start", oTxD_Start, 1'b0);
        check("async_rst_count", oCOUNT, 0);
        check("async_rst_empty", oEMPTY, 1'b1);
        sbQ.delete();
        tick();
        tick();
        RST_n = 1'b1;
        base  = startCount;
        repeat (30) tick();
        check("no_resume_after_reset", startCount, base);
        writeByte(8'h5A, 1'b1);
        waitStartPulse(10);
        RST_n = 1'b0;
        #1;
        check("async_rst_kills_pulse", oTxD_Start, 1'b0);
        sbQ.delete();
        tick();
        RST_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
